// File: rtl/mips_defs.sv
// Shared MIPS decode constants and writeback-stage enums.
package mips_defs;

    localparam int WORD_W = 32;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_LB      = 6'b100000;
    localparam logic [5:0] OP_LH      = 6'b100001;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_LBU     = 6'b100100;
    localparam logic [5:0] OP_LHU     = 6'b100101;
    localparam logic [5:0] FUNCT_JALR = 6'b001001;

    typedef enum logic [2:0] {
        LD_NONE,
        LD_W,
        LD_B,
        LD_BU,
        LD_H,
        LD_HU
    } ld_type_e;

    typedef enum logic [1:0] {
        WB_ALU,
        WB_MEM,
        WB_PC8
    } wb_sel_e;

endpackage

// File: rtl/load_ext.sv
// Load data extractor: picks the byte/halfword addressed by the low address bits and extends it.
module load_ext
    import mips_defs::*;
(
    input  ld_type_e          ld_type_i,
    input  logic [1:0]        off_i,
    input  logic [WORD_W-1:0] dm_i,
    output logic [WORD_W-1:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        // Little-endian lanes; off_i[0] is ignored for halfwords.
        case (off_i)
            2'd0:    byte_sel = dm_i[7:0];
            2'd1:    byte_sel = dm_i[15:8];
            2'd2:    byte_sel = dm_i[23:16];
            default: byte_sel = dm_i[31:24];
        endcase
        half_sel = off_i[1] ? dm_i[31:16] : dm_i[15:0];

        case (ld_type_i)
            LD_B:    ext_o = {{24{byte_sel[7]}}, byte_sel};
            LD_BU:   ext_o = {24'd0, byte_sel};
            LD_H:    ext_o = {{16{half_sel[15]}}, half_sel};
            LD_HU:   ext_o = {16'd0, half_sel};
            default: ext_o = dm_i;
        endcase
    end

endmodule

// File: rtl/wb_grf.sv
// Writeback stage: selects final write data, owns the 32x32 GRF, serves D-stage reads with W->D bypass.
// Defining GRF_TRACE_EN adds a simulation-only print of every register write.
module wb_grf
    import mips_defs::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_w,
    input  logic [DATA_W-1:0] aluout_w,
    input  logic [DATA_W-1:0] dm_w,
    input  logic [31:0]       pc4_w,
    input  logic [31:0]       pc8_w,
    input  logic [REG_AW-1:0] a3_w,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] wd_w,
    output logic              we_w
);

    localparam int NREGS = 2 ** REG_AW;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    ld_type_e          ld_type;
    wb_sel_e           wb_sel;
    logic [DATA_W-1:0] ext_data;

    // Register 0 is hardwired to zero, so only 1..NREGS-1 are stored.
    logic [DATA_W-1:0] regs_q [1:NREGS-1];

    assign opcode = instr_w[31:26];
    assign funct  = instr_w[5:0];

    always_comb begin
        ld_type = LD_NONE;
        wb_sel  = WB_ALU;
        case (opcode)
            OP_LW:  begin ld_type = LD_W;  wb_sel = WB_MEM; end
            OP_LB:  begin ld_type = LD_B;  wb_sel = WB_MEM; end
            OP_LBU: begin ld_type = LD_BU; wb_sel = WB_MEM; end
            OP_LH:  begin ld_type = LD_H;  wb_sel = WB_MEM; end
            OP_LHU: begin ld_type = LD_HU; wb_sel = WB_MEM; end
            OP_JAL: wb_sel = WB_PC8;
            OP_SPECIAL: begin
                if (funct == FUNCT_JALR) wb_sel = WB_PC8;
            end
            default: ;
        endcase
    end

    load_ext u_load_ext (
        .ld_type_i (ld_type),
        .off_i     (aluout_w[1:0]),
        .dm_i      (dm_w),
        .ext_o     (ext_data)
    );

    always_comb begin
        case (wb_sel)
            WB_MEM:  wd_w = ext_data;
            WB_PC8:  wd_w = pc8_w;
            default: wd_w = aluout_w;
        endcase
    end

    assign we_w = (a3_w != '0) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREGS; i++) regs_q[i] <= '0;
        end else if (we_w) begin
            regs_q[a3_w] <= wd_w;
        end
    end

    // we_w already excludes address 0 and reset, so it alone gates the bypass.
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) rd1 = (we_w && ra1 == a3_w) ? wd_w : regs_q[ra1];
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) rd2 = (we_w && ra2 == a3_w) ? wd_w : regs_q[ra2];
    end

    wire unused_instr = &{1'b0, instr_w[25:6]};

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (we_w) $display("@%h: $%0d <= %h", pc4_w - 32'd4, a3_w, wd_w);
    end
`else
    wire unused_pc4 = &{1'b0, pc4_w};
`endif

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: directed scenarios plus randomized traffic against a register-array model.
module tb_wb_grf;

    localparam logic [5:0] T_SPECIAL = 6'b000000;
    localparam logic [5:0] T_JAL     = 6'b000011;
    localparam logic [5:0] T_LB      = 6'b100000;
    localparam logic [5:0] T_LH      = 6'b100001;
    localparam logic [5:0] T_LW      = 6'b100011;
    localparam logic [5:0] T_LBU     = 6'b100100;
    localparam logic [5:0] T_LHU     = 6'b100101;
    localparam logic [5:0] T_ADDU    = 6'b100001;
    localparam logic [5:0] T_JALR    = 6'b001001;

    localparam logic [5:0]  LD_OP  [6] = '{T_LB, T_LBU, T_LB, T_LH, T_LHU, T_LW};
    localparam logic [31:0] LD_DM  [6] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01,
                                          32'h8001FFFF, 32'h8001FFFF, 32'h8001FFFF};
    localparam logic [1:0]  LD_OFF [6] = '{2'd3, 2'd3, 2'd1, 2'd2, 2'd3, 2'd2};
    localparam logic [31:0] LD_EXP [6] = '{32'hFFFFFF80, 32'h00000080, 32'h0000007F,
                                          32'hFFFF8001, 32'h00008001, 32'h8001FFFF};

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_w, aluout_w, dm_w, pc4_w, pc8_w;
    logic [4:0]  a3_w, ra1, ra2;
    logic [31:0] rd1, rd2, wd_w;
    logic        we_w;

    int checks = 0;
    int errors = 0;

    logic [31:0] model_q [32];

    wb_grf dut (
        .clk      (clk),
        .reset    (reset),
        .instr_w  (instr_w),
        .aluout_w (aluout_w),
        .dm_w     (dm_w),
        .pc4_w    (pc4_w),
        .pc8_w    (pc8_w),
        .a3_w     (a3_w),
        .ra1      (ra1),
        .ra2      (ra2),
        .rd1      (rd1),
        .rd2      (rd2),
        .wd_w     (wd_w),
        .we_w     (we_w)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_instr(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'd0, fn};
    endfunction

    // Reference write data, computed from the decode rules with shifts and arithmetic.
    function automatic logic [31:0] exp_wd(input logic [31:0] instr, input logic [31:0] alu,
                                           input logic [31:0] dm, input logic [31:0] pc8);
        logic [31:0] b, h;
        int off;
        off = int'(alu[1:0]);
        b = (dm >> (8 * off)) & 32'hFF;
        h = (dm >> (16 * (off / 2))) & 32'hFFFF;
        case (instr[31:26])
            T_LW:  return dm;
            T_LB:  return b + ((b >= 32'd128) ? 32'hFFFFFF00 : 32'd0);
            T_LBU: return b;
            T_LH:  return h + ((h >= 32'd32768) ? 32'hFFFF0000 : 32'd0);
            T_LHU: return h;
            T_JAL: return pc8;
            T_SPECIAL: return (instr[5:0] == T_JALR) ? pc8 : alu;
            default: return alu;
        endcase
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (!reset && a3_w != 5'd0 && ra == a3_w) return exp_wd(instr_w, aluout_w, dm_w, pc8_w);
        return model_q[ra];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model_q[i] <= 32'd0;
        end else if (a3_w != 5'd0) begin
            model_q[a3_w] <= exp_wd(instr_w, aluout_w, dm_w, pc8_w);
        end
    end

    task automatic drive(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] dm,
                         input logic [31:0] pc8, input logic [4:0] a3, input logic [4:0] r1,
                         input logic [4:0] r2);
        instr_w  = instr;
        aluout_w = alu;
        dm_w     = dm;
        pc8_w    = pc8;
        pc4_w    = pc8 - 32'd4;
        a3_w     = a3;
        ra1      = r1;
        ra2      = r2;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(mk_instr(T_SPECIAL, T_ADDU), 32'h55555555, 32'd0, 32'd8, 5'd5, 5'd5, 5'd0);
        checks++;
        if (we_w !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", we_w); end
        repeat (3) next_cycle();
        reset = 1'b0;
        drive(mk_instr(T_SPECIAL, T_ADDU), 32'h0BADF00D, 32'd0, 32'd8, 5'd0, 5'd5, 5'd0);
        checks++;
        if (rd1 !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h exp 0", rd1); end
        checks++;
        if (rd2 !== 32'd0) begin errors++; $display("FAIL reset_rd2 got %h exp 0", rd2); end
        checks++;
        if (we_w !== 1'b0) begin errors++; $display("FAIL a3zero_we got %b exp 0", we_w); end
        next_cycle();
        for (int r = 0; r < 32; r++) begin
            drive(mk_instr(T_SPECIAL, T_ADDU), 32'd0, 32'd0, 32'd8, 5'd0, 5'(r), 5'(31 - r));
            checks++;
            if (rd1 !== 32'd0) begin errors++; $display("FAIL after_reset_rd1[%0d] got %h exp 0", r, rd1); end
        end
    endtask

    task automatic test_bypass();
        drive(mk_instr(T_SPECIAL, T_ADDU), 32'h12345678, 32'h0, 32'h100, 5'd8, 5'd8, 5'd8);
        checks++;
        if (we_w !== 1'b1) begin errors++; $display("FAIL bypass_we got %b exp 1", we_w); end
        checks++;
        if (wd_w !== 32'h12345678) begin errors++; $display("FAIL bypass_wd got %h exp 12345678", wd_w); end
        checks++;
        if (rd1 !== 32'h12345678) begin errors++; $display("FAIL bypass_rd1 got %h exp 12345678", rd1); end
        checks++;
        if (rd2 !== 32'h12345678) begin errors++; $display("FAIL bypass_rd2 got %h exp 12345678", rd2); end
        next_cycle();
        drive(mk_instr(T_SPECIAL, T_ADDU), 32'h99999999, 32'h0, 32'h100, 5'd0, 5'd8, 5'd7);
        checks++;
        if (rd1 !== 32'h12345678) begin errors++; $display("FAIL stored_rd1 got %h exp 12345678", rd1); end
        checks++;
        if (rd2 !== 32'd0) begin errors++; $display("FAIL stored_rd2 got %h exp 0", rd2); end
        next_cycle();
    endtask

    task automatic test_loads();
        for (int i = 0; i < 6; i++) begin
            drive(mk_instr(LD_OP[i], 6'd0), {$urandom_range(0, 32'h3FFFFFFF), LD_OFF[i]}, LD_DM[i],
                  32'h200, 5'(10 + i), 5'(10 + i), 5'(9 + i));
            checks++;
            if (wd_w !== LD_EXP[i]) begin errors++; $display("FAIL load_wd[%0d] got %h exp %h", i, wd_w, LD_EXP[i]); end
            checks++;
            if (rd1 !== LD_EXP[i]) begin errors++; $display("FAIL load_rd1[%0d] got %h exp %h", i, rd1, LD_EXP[i]); end
            checks++;
            if (rd2 !== model_q[9 + i]) begin errors++; $display("FAIL load_rd2[%0d] got %h exp %h", i, rd2, model_q[9 + i]); end
            next_cycle();
        end
    endtask

    task automatic test_jal();
        drive(mk_instr(T_JAL, 6'd0), 32'h77777777, 32'h0, 32'h00003008, 5'd31, 5'd0, 5'd0);
        checks++;
        if (wd_w !== 32'h00003008) begin errors++; $display("FAIL jal_wd got %h exp 00003008", wd_w); end
        next_cycle();
        drive(mk_instr(T_SPECIAL, T_JALR), 32'h66666666, 32'h0, 32'h00004010, 5'd30, 5'd31, 5'd30);
        checks++;
        if (rd1 !== 32'h00003008) begin errors++; $display("FAIL jal_rd31 got %h exp 00003008", rd1); end
        checks++;
        if (rd2 !== 32'h00004010) begin errors++; $display("FAIL jalr_bypass got %h exp 00004010", rd2); end
        next_cycle();
        drive(mk_instr(T_SPECIAL, T_ADDU), 32'hDEADBEEF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd30);
        checks++;
        if (we_w !== 1'b0) begin errors++; $display("FAIL r0_we got %b exp 0", we_w); end
        next_cycle();
        drive(mk_instr(T_JAL, 6'd0), 32'h0, 32'h0, 32'h00005000, 5'd0, 5'd0, 5'd30);
        checks++;
        if (rd1 !== 32'd0) begin errors++; $display("FAIL r0_rd1 got %h exp 0", rd1); end
        checks++;
        if (rd2 !== 32'h00004010) begin errors++; $display("FAIL jalr_rd30 got %h exp 00004010", rd2); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        drive(mk_instr(T_SPECIAL, T_ADDU), 32'h11111111, 32'h0, 32'h0, 5'd9, 5'd0, 5'd0);
        next_cycle();
        reset = 1'b1;
        drive(mk_instr(T_SPECIAL, T_ADDU), 32'hAAAA0000, 32'h0, 32'h0, 5'd9, 5'd9, 5'd31);
        checks++;
        if (we_w !== 1'b0) begin errors++; $display("FAIL midrst_we got %b exp 0", we_w); end
        checks++;
        if (rd1 !== 32'h11111111) begin errors++; $display("FAIL midrst_nobypass got %h exp 11111111", rd1); end
        checks++;
        if (wd_w !== 32'hAAAA0000) begin errors++; $display("FAIL midrst_wd got %h exp aaaa0000", wd_w); end
        next_cycle();
        reset = 1'b0;
        for (int r = 0; r < 32; r++) begin
            drive(mk_instr(T_SPECIAL, T_ADDU), 32'h0, 32'h0, 32'h0, 5'd0, 5'(r), 5'(31 - r));
            checks++;
            if (rd1 !== 32'd0 || rd2 !== 32'd0) begin
                errors++;
                $display("FAIL midrst_clear[%0d] got %h/%h exp 0/0", r, rd1, rd2);
            end
        end
        next_cycle();
    endtask

    task automatic test_random();
        logic [31:0] instr, e;
        logic [4:0]  a3, r1, r2;
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 8))
                0: instr = mk_instr(T_LW, 6'($urandom));
                1: instr = mk_instr(T_LB, 6'($urandom));
                2: instr = mk_instr(T_LBU, 6'($urandom));
                3: instr = mk_instr(T_LH, 6'($urandom));
                4: instr = mk_instr(T_LHU, 6'($urandom));
                5: instr = mk_instr(T_JAL, 6'($urandom));
                6: instr = mk_instr(T_SPECIAL, T_JALR);
                7: instr = mk_instr(T_SPECIAL, T_ADDU);
                default: instr = $urandom;
            endcase
            a3 = 5'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
            drive(instr, $urandom, $urandom, $urandom, a3, r1, r2);
            e = exp_wd(instr_w, aluout_w, dm_w, pc8_w);
            checks++;
            if (wd_w !== e) begin errors++; $display("FAIL rand_wd[%0d] got %h exp %h", n, wd_w, e); end
            checks++;
            if (we_w !== (a3 != 5'd0)) begin errors++; $display("FAIL rand_we[%0d] got %b exp %b", n, we_w, a3 != 5'd0); end
            checks++;
            if (rd1 !== exp_rd(r1)) begin errors++; $display("FAIL rand_rd1[%0d] got %h exp %h", n, rd1, exp_rd(r1)); end
            checks++;
            if (rd2 !== exp_rd(r2)) begin errors++; $display("FAIL rand_rd2[%0d] got %h exp %h", n, rd2, exp_rd(r2)); end
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        instr_w = '0; aluout_w = '0; dm_w = '0; pc4_w = '0; pc8_w = '0;
        a3_w = '0; ra1 = '0; ra2 = '0;
        #1;
        test_reset();
        test_bypass();
        test_loads();
        test_jal();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
